// File: rtl/dsc_sn_decoder.sv
// Stochastic-number decoder: counts the ones in a framed bitstream and reports
// the binary count together with frame-length and saturation flags.
module dsc_sn_decoder #(
  parameter int NUM_BITS   = 8,
  parameter int NUM_INPUTS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           sn_in,
  input  logic                           sn_valid,
  input  logic                           sn_last,
  output logic                           sn_ready,
  output logic [NUM_INPUTS*NUM_BITS-1:0] z,
  output logic                           z_valid,
  input  logic                           z_ready,
  output logic                           len_err,
  output logic                           sat
);

  localparam int W = NUM_INPUTS * NUM_BITS;
  localparam logic [W-1:0] ONES_MAX  = '1;
  localparam logic [W:0]   BEATS_MAX = '1;
  localparam logic [W:0]   FRAME_LEN = {1'b1, {W{1'b0}}};

  // state | meaning
  // IDLE  | waiting for the first beat of a frame
  // ACC   | accumulating ones and beats
  // DONE  | result held on z until the consumer takes it
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t         r_state;
  logic [W-1:0]   r_ones;
  logic [W:0]     r_beats;
  logic [W-1:0]   r_z;
  logic           r_z_valid;
  logic           r_sn_ready;
  logic           r_len_err;
  logic           r_sat;

  logic [W-1:0]   w_ones_nxt;
  logic [W:0]     w_beats_nxt;
  logic           w_sat_hit;
  logic           w_first;

  assign w_first = (r_state == IDLE);

  always_comb begin
    w_ones_nxt  = r_ones;
    w_beats_nxt = r_beats;
    w_sat_hit   = 1'b0;
    if (w_first) begin
      w_ones_nxt  = W'(sn_in);
      w_beats_nxt = (W+1)'(1);
    end else begin
      if (sn_in) begin
        if (r_ones == ONES_MAX) w_sat_hit  = 1'b1;
        else                    w_ones_nxt = r_ones + 1'b1;
      end
      if (r_beats != BEATS_MAX) w_beats_nxt = r_beats + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ones     <= '0;
      r_beats    <= '0;
      r_z        <= '0;
      r_z_valid  <= 1'b0;
      r_sn_ready <= 1'b1;
      r_len_err  <= 1'b0;
      r_sat      <= 1'b0;
    end else if (en) begin
      unique case (r_state)
        IDLE, ACC: begin
          if (sn_valid) begin
            r_ones  <= w_ones_nxt;
            r_beats <= w_beats_nxt;
            // the first beat of a frame clears the previous frame's flags
            r_sat   <= w_first ? 1'b0 : (r_sat | w_sat_hit);
            if (w_first) r_len_err <= 1'b0;
            if (sn_last) begin
              r_z        <= w_ones_nxt;
              r_len_err  <= (w_beats_nxt != FRAME_LEN);
              r_z_valid  <= 1'b1;
              r_sn_ready <= 1'b0;
              r_state    <= DONE;
            end else begin
              r_state <= ACC;
            end
          end
        end
        DONE: begin
          if (z_ready) begin
            r_z_valid  <= 1'b0;
            r_sn_ready <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sn_ready = r_sn_ready;
  assign z        = r_z;
  assign z_valid  = r_z_valid;
  assign len_err  = r_len_err;
  assign sat      = r_sat;

endmodule

// File: tb/tb_dsc_sn_decoder.sv
// Scoreboard bench for dsc_sn_decoder: a small W=4 instance for directed
// frames and a default-parameter instance for one full 65536-beat frame.
module tb_dsc_sn_decoder;

  typedef struct packed {
    logic [31:0] z;
    logic        le;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;

  logic       s_in = 1'b0, s_valid = 1'b0, s_last = 1'b0, s_zready = 1'b0;
  logic       s_ready, s_zvalid, s_le, s_sat;
  logic [3:0] s_z;

  logic        l_in = 1'b0, l_valid = 1'b0, l_last = 1'b0, l_zready = 1'b0;
  logic        l_ready, l_zvalid, l_le, l_sat;
  logic [15:0] l_z;

  int n_vec  = 0;
  int n_miss = 0;
  exp_t s_q[$];
  exp_t l_q[$];
  logic s_prev = 1'b0;
  logic l_prev = 1'b0;

  always #5 clk = ~clk;

  dsc_sn_decoder #(.NUM_BITS(2), .NUM_INPUTS(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .sn_in(s_in), .sn_valid(s_valid),
    .sn_last(s_last), .sn_ready(s_ready), .z(s_z), .z_valid(s_zvalid),
    .z_ready(s_zready), .len_err(s_le), .sat(s_sat)
  );

  dsc_sn_decoder dut_l (
    .clk(clk), .rst(rst), .en(en), .sn_in(l_in), .sn_valid(l_valid),
    .sn_last(l_last), .sn_ready(l_ready), .z(l_z), .z_valid(l_zvalid),
    .z_ready(l_zready), .len_err(l_le), .sat(l_sat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitors: compare on every rising edge of z_valid
  always @(negedge clk) begin
    if (s_zvalid && !s_prev) begin
      if (s_q.size() == 0) begin
        check("s_unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = s_q.pop_front();
        check("s_z", {28'd0, s_z}, e.z);
        check("s_len_err", {31'd0, s_le}, {31'd0, e.le});
        check("s_sat", {31'd0, s_sat}, {31'd0, e.sat});
      end
    end
    s_prev <= s_zvalid;
  end

  always @(negedge clk) begin
    if (l_zvalid && !l_prev) begin
      if (l_q.size() == 0) begin
        check("l_unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = l_q.pop_front();
        check("l_z", {16'd0, l_z}, e.z);
        check("l_len_err", {31'd0, l_le}, {31'd0, e.le});
        check("l_sat", {31'd0, l_sat}, {31'd0, e.sat});
      end
    end
    l_prev <= l_zvalid;
  end

  // n beats taken from bits[0..n-1]; two invalid cycles (sn_in=1) before beat gap_at
  task automatic s_frame(input logic [31:0] bits, input int n, input int gap_at,
                         input logic [31:0] ez, input logic ele, input logic esat);
    exp_t e;
    e.z = ez; e.le = ele; e.sat = esat;
    s_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        repeat (2) begin
          @(negedge clk);
          s_valid = 1'b0; s_in = 1'b1; s_last = 1'b0;
        end
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_in    = bits[i];
      s_last  = (i == n - 1);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_in = 1'b0;
    check("s_zvalid_latency", {31'd0, s_zvalid}, 32'd1);
    check("s_ready_in_done", {31'd0, s_ready}, 32'd0);
  endtask

  task automatic s_accept();
    s_zready = 1'b1;
    @(negedge clk);
    s_zready = 1'b0;
    check("s_release_zvalid", {31'd0, s_zvalid}, 32'd0);
    check("s_release_ready", {31'd0, s_ready}, 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] z_hold;
    int         k;
    repeat (3) @(negedge clk);
    check("rst_z", {28'd0, s_z}, 32'd0);
    check("rst_zvalid", {31'd0, s_zvalid}, 32'd0);
    check("rst_ready", {31'd0, s_ready}, 32'd1);
    check("rst_len_err", {31'd0, s_le}, 32'd0);
    check("rst_sat", {31'd0, s_sat}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 16 beats, 9 ones
    s_frame(32'h0000_B6CA, 16, -1, 32'd9, 1'b0, 1'b0);
    s_accept();
    // all ones: count saturates at 15
    s_frame(32'h0000_FFFF, 16, -1, 32'd15, 1'b0, 1'b1);
    s_accept();
    // short frame, 10 beats with 4 ones, gaps mid-frame
    s_frame(32'h0000_0189, 10, 3, 32'd4, 1'b1, 1'b0);
    s_accept();
    // single-beat frame: IDLE straight to DONE
    s_frame(32'h0000_0001, 1, -1, 32'd1, 1'b1, 1'b0);
    s_accept();

    // hold in DONE with beats presented and z_ready low
    s_frame(32'h0000_00FE, 16, -1, 32'd7, 1'b0, 1'b0);
    z_hold = s_z;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_in = 1'b1;
      @(negedge clk);
      check("hold_z", {28'd0, s_z}, 32'd7);
      check("hold_ready", {31'd0, s_ready}, 32'd0);
    end
    s_valid = 1'b0; s_in = 1'b0;
    check("hold_z_start", {28'd0, z_hold}, 32'd7);
    en = 1'b0; s_zready = 1'b1;
    @(negedge clk);
    s_zready = 1'b0; en = 1'b1;
    check("en_low_ignores_ready", {31'd0, s_zvalid}, 32'd1);
    s_accept();
    check("z_held_after_accept", {28'd0, s_z}, 32'd7);
    s_frame(32'h0000_001F, 16, -1, 32'd5, 1'b0, 1'b0);
    s_accept();

    // reset mid-frame after 7 beats
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_in = 1'b1; s_last = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_z", {28'd0, s_z}, 32'd0);
    check("midrst_zvalid", {31'd0, s_zvalid}, 32'd0);
    check("midrst_ready", {31'd0, s_ready}, 32'd1);
    check("midrst_len_err", {31'd0, s_le}, 32'd0);
    check("midrst_sat", {31'd0, s_sat}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    s_frame(32'h0000_0007, 16, -1, 32'd3, 1'b0, 1'b0);
    s_accept();

    // default parameters: 65536 beats, 20000 ones spread evenly
    begin
      exp_t e;
      e.z = 32'd20000; e.le = 1'b0; e.sat = 1'b0;
      l_q.push_back(e);
    end
    k = 0;
    for (int i = 0; i < 65536; i++) begin
      logic [31:0] acc;
      if (i == 30000) begin
        @(negedge clk);
        en = 1'b0; l_valid = 1'b1; l_in = 1'b1; l_last = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1; l_valid = 1'b0;
      end
      acc = (i * 20000) % 65536;
      @(negedge clk);
      l_valid = 1'b1;
      l_in    = ((acc + 32'd20000) >= 32'd65536);
      l_last  = (i == 65535);
      if (l_in) k++;
    end
    @(negedge clk);
    l_valid = 1'b0; l_last = 1'b0; l_in = 1'b0;
    check("l_ones_driven", k, 32'd20000);
    check("l_zvalid_latency", {31'd0, l_zvalid}, 32'd1);
    l_zready = 1'b1;
    @(negedge clk);
    l_zready = 1'b0;
    check("l_release_zvalid", {31'd0, l_zvalid}, 32'd0);

    repeat (3) @(negedge clk);
    check("s_queue_drained", s_q.size(), 32'd0);
    check("l_queue_drained", l_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dsc_sn_decoder.md
DSC_SN_DECODER -- requirements
Module: dsc_sn_decoder

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, meaning the width of each binary operand of the upstream stochastic multiplier.
REQ-002 SHALL have parameter NUM_INPUTS, default 2, meaning the number of operands; W = NUM_INPUTS*NUM_BITS and the nominal frame length is L = 2^W beats.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, global enable; when 0, all state SHALL be frozen.
REQ-006 SHALL have port sn_in, input, 1, the stochastic bitstream data bit.
REQ-007 SHALL have port sn_valid, input, 1, qualifying sn_in as a beat.
REQ-008 SHALL have port sn_last, input, 1, marking the final beat of a frame; it is qualified by sn_valid.
REQ-009 SHALL have port sn_ready, output, 1, asserted when the block accepts beats.
REQ-010 SHALL have port z, output, W, the binary ones-count of the frame.
REQ-011 SHALL have port z_valid, output, 1, asserted while z holds a completed result.
REQ-012 SHALL have port z_ready, input, 1, the consumer acceptance of z.
REQ-013 SHALL have port len_err, output, 1, indicating the frame beat count was not equal to L.
REQ-014 SHALL have port sat, output, 1, indicating the ones-count saturated.

Function
REQ-015 SHALL implement a state machine with states IDLE, ACC and DONE.
REQ-016 A beat SHALL occur in a cycle only when en=1, sn_valid=1 and sn_ready=1; sn_ready SHALL be 1 in IDLE and ACC and 0 in DONE.
REQ-017 IDLE: a beat SHALL load ones=sn_in and beats=1, then go to ACC, or go directly to DONE if sn_last=1.
REQ-018 ACC: each beat SHALL add sn_in to ones and increment beats; a beat with sn_last=1 SHALL go to DONE.
REQ-019 Cycles without a beat SHALL leave ones, beats and state unchanged; no timeout applies.
REQ-020 ones SHALL be W bits and saturate at 2^W-1; sat SHALL be set if any increment is attempted at 2^W-1.
REQ-021 beats SHALL be W+1 bits and saturate at 2^(W+1)-1.
REQ-022 On entering DONE, z SHALL equal ones including the last beat, with z_valid=1 one cycle after the last beat.
REQ-023 On entering DONE, len_err SHALL be set iff beats != L.
REQ-024 In DONE, z, sat and len_err SHALL stay stable until z_valid & z_ready & en.
REQ-025 When z_valid & z_ready & en, the block SHALL go to IDLE next cycle with z_valid=0; z, sat and len_err SHALL hold their last values until the next frame's first beat clears sat and len_err.
REQ-026 Beats presented while sn_ready=0 SHALL be ignored.
REQ-027 When en=0 in any state, the state SHALL hold; z_ready SHALL be ignored.

Reset
REQ-028 While rst=0, the block SHALL asynchronously force state=IDLE, ones=0, beats=0, z=0, z_valid=0, sn_ready=1, len_err=0 and sat=0, including mid-frame, and any partial frame SHALL be discarded.
REQ-029 After rst returns to 1, the first beat SHALL start a fresh frame.

Verification
REQ-030 NUM_BITS=2 (W=4, L=16): 16 beats containing 9 ones, sn_last on beat 16 -> next cycle z=9, z_valid=1, len_err=0, sat=0.
REQ-031 NUM_BITS=2: 16 beats all ones -> z=15, sat=1, len_err=0.
REQ-032 NUM_BITS=2: sn_last on beat 10 with 4 ones -> z=4, len_err=1; gaps of sn_valid=0 inserted mid-frame do not change z.
REQ-033 Hold z_ready=0 for 5 cycles in DONE while driving beats -> z stable, sn_ready=0, beats ignored; z_ready=1 -> IDLE next cycle, next frame counts from 0.
REQ-034 rst pulsed low after 7 beats -> all outputs 0 immediately; following full frame of 3 ones -> z=3.
REQ-035 Default parameters: 65536-beat frame with exactly 20000 ones (product of a=200, b=100) -> z=20000, len_err=0, sat=0; en toggled low mid-frame does not alter the result.
